// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory
// freeze with a wait-cycle timeout, plus saturating stall/flush event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned WAIT_MAX = 16
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rt_i,
   input  logic        branch_taken_i,
   input  logic        mem_req_i,
   input  logic        dm_ready_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        pipe_hold_o,
   output logic        idex_bubble_o,
   output logic        ifid_flush_o,
   output logic        idex_flush_o,
   output logic        exmem_flush_o,
   output logic [1:0]  state_o,
   output logic        err_o,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] TIMEOUT  = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
   localparam int         N_CNT     = 2;

   logic [1:0]  state_reg, state_next;
   logic [7:0]  wait_cnt_reg, wait_cnt_next;
   logic        freeze;
   logic        load_use;
   logic        in_timeout;
   logic        branch_flush;
   logic [N_CNT-1:0] cnt_inc;
   logic [15:0] evt_cnt_reg [N_CNT];

   assign freeze     = mem_req_i & ~dm_ready_i;
   assign load_use   = ex_memread_i && (ex_rt_i != 5'd0) &&
                       ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
   assign in_timeout = (state_reg == TIMEOUT);

   // Priority: timeout, freeze, branch, load-use, normal. A branch seen during
   // a freeze is held in MEM by the frozen pipeline and acted on afterwards.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      pipe_hold_o   = 1'b0;
      idex_bubble_o = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      branch_flush  = 1'b0;
      if (in_timeout || freeze) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         pipe_hold_o  = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
         branch_flush  = 1'b1;
      end else if (load_use) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN: begin
            if (freeze)
               state_next = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (!freeze)
               state_next = RUN;
            else if (wait_cnt_reg == WAIT_LAST)
               state_next = TIMEOUT;
         end
         TIMEOUT: state_next = TIMEOUT;
         default: state_next = RUN;
      endcase
   end

   // Counts consecutive freeze cycles; any non-freeze cycle restarts it.
   always_comb begin
      wait_cnt_next = 8'd0;
      if (freeze)
         wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= RUN;
         wait_cnt_reg <= 8'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   assign cnt_inc[0] = ~pc_write_o;
   assign cnt_inc[1] = branch_flush;

   generate
      for (genvar gi = 0; gi < N_CNT; gi++) begin : g_evt_cnt
         always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n)
               evt_cnt_reg[gi] <= 16'd0;
            else if (cnt_inc[gi] && (evt_cnt_reg[gi] != 16'hFFFF))
               evt_cnt_reg[gi] <= evt_cnt_reg[gi] + 16'd1;
         end
      end
   endgenerate

   assign stall_cnt_o = evt_cnt_reg[0];
   assign flush_cnt_o = evt_cnt_reg[1];
   assign state_o     = state_reg;
   assign err_o       = in_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX = 16).
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
   logic        ex_memread_i = 1'b0, branch_taken_i = 1'b0;
   logic        mem_req_i = 1'b0, dm_ready_i = 1'b1;
   logic        pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o;
   logic        ifid_flush_o, idex_flush_o, exmem_flush_o, err_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o, flush_cnt_o;

   int checks = 0;
   int failures = 0;

   pipe_hazard_ctrl #(.WAIT_MAX(16)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
      .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .dm_ready_i(dm_ready_i),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .pipe_hold_o(pipe_hold_o),
      .idex_bubble_o(idex_bubble_o), .ifid_flush_o(ifid_flush_o),
      .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
      .state_o(state_o), .err_o(err_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #5ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Drive: {memread, ex_rt, id_rs, id_rt, branch, mem_req, dm_ready}
   task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rtt, input logic br, input logic mq, input logic rdy);
      ex_memread_i = mr; ex_rt_i = rt; id_rs_i = rs; id_rt_i = rtt;
      branch_taken_i = br; mem_req_i = mq; dm_ready_i = rdy;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      idle();
      @(posedge clk_i);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      #1;
      checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
      checks++; if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin failures++;
         $display("FAIL reset_cnt got=%0h/%0h exp=0/0", stall_cnt_o, flush_cnt_o); end
      checks++; if ({pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o} !== 4'b1100) begin failures++;
         $display("FAIL reset_ctrl got=%b exp=1100", {pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o}); end
      $display("test_reset done");
   endtask

   task automatic test_load_use();
      apply_reset();
      drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1);
      #1;
      checks++; if ({pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o} !== 4'b0001) begin failures++;
         $display("FAIL lu_ctrl got=%b exp=0001", {pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o}); end
      next_cycle();
      idle();
      #1;
      checks++; if (stall_cnt_o !== 16'd1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall_cnt_o); end
      checks++; if (pc_write_o !== 1'b1 || idex_bubble_o !== 1'b0) begin failures++;
         $display("FAIL lu_release got=%b%b exp=10", pc_write_o, idex_bubble_o); end
      // Match on rt side only
      drive(1'b1, 5'd17, 5'd2, 5'd17, 1'b0, 1'b0, 1'b1);
      #1;
      checks++; if (idex_bubble_o !== 1'b1) begin failures++; $display("FAIL lu_rt_bubble got=%b exp=1", idex_bubble_o); end
      next_cycle();
      idle();
      $display("test_load_use done");
   endtask

   task automatic test_rt_zero();
      apply_reset();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++; if (pc_write_o !== 1'b1 || idex_bubble_o !== 1'b0) begin failures++;
         $display("FAIL r0_ctrl got=%b%b exp=10", pc_write_o, idex_bubble_o); end
      next_cycle();
      checks++; if (stall_cnt_o !== 16'd0) begin failures++; $display("FAIL r0_stall got=%0d exp=0", stall_cnt_o); end
      idle();
      $display("test_rt_zero done");
   endtask

   task automatic test_branch_load();
      apply_reset();
      drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      checks++; if ({ifid_flush_o, idex_flush_o, exmem_flush_o, idex_bubble_o, pc_write_o} !== 5'b11101) begin failures++;
         $display("FAIL br_ctrl got=%b exp=11101", {ifid_flush_o, idex_flush_o, exmem_flush_o, idex_bubble_o, pc_write_o}); end
      next_cycle();
      idle();
      #1;
      checks++; if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin failures++;
         $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt_o, stall_cnt_o); end
      $display("test_branch_load done");
   endtask

   task automatic test_freeze_branch();
      apply_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      #1;
      checks++; if (state_o !== 2'd0 || pipe_hold_o !== 1'b1 || pc_write_o !== 1'b0 || ifid_flush_o !== 1'b0) begin failures++;
         $display("FAIL fz_c1 got=st%0d h%b p%b f%b exp=st0 h1 p0 f0", state_o, pipe_hold_o, pc_write_o, ifid_flush_o); end
      for (int i = 2; i <= 3; i++) begin
         next_cycle();
         checks++; if (state_o !== 2'd1 || pipe_hold_o !== 1'b1 || exmem_flush_o !== 1'b0) begin failures++;
            $display("FAIL fz_c%0d got=st%0d h%b f%b exp=st1 h1 f0", i, state_o, pipe_hold_o, exmem_flush_o); end
      end
      next_cycle();
      dm_ready_i = 1'b1;
      #1;
      checks++; if (state_o !== 2'd1 || {ifid_flush_o, idex_flush_o, exmem_flush_o} !== 3'b111 || pc_write_o !== 1'b1) begin failures++;
         $display("FAIL fz_c4 got=st%0d f%b p%b exp=st1 f111 p1", state_o, {ifid_flush_o, idex_flush_o, exmem_flush_o}, pc_write_o); end
      next_cycle();
      idle();
      #1;
      checks++; if (state_o !== 2'd0 || stall_cnt_o !== 16'd3 || flush_cnt_o !== 16'd1) begin failures++;
         $display("FAIL fz_end got=st%0d s%0d f%0d exp=st0 s3 f1", state_o, stall_cnt_o, flush_cnt_o); end
      $display("test_freeze_branch done");
   endtask

   task automatic test_single_freeze();
      apply_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      next_cycle();
      dm_ready_i = 1'b1;
      #1;
      checks++; if (pc_write_o !== 1'b1 || pipe_hold_o !== 1'b0) begin failures++;
         $display("FAIL sf_release got=p%b h%b exp=p1 h0", pc_write_o, pipe_hold_o); end
      next_cycle();
      idle();
      checks++; if (stall_cnt_o !== 16'd1 || state_o !== 2'd0) begin failures++;
         $display("FAIL sf_cnt got=s%0d st%0d exp=s1 st0", stall_cnt_o, state_o); end
      $display("test_single_freeze done");
   endtask

   task automatic test_wait_boundary();
      apply_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      repeat (15) next_cycle();
      dm_ready_i = 1'b1;
      next_cycle();
      checks++; if (state_o !== 2'd0 || err_o !== 1'b0) begin failures++;
         $display("FAIL wb_15 got=st%0d e%b exp=st0 e0", state_o, err_o); end
      dm_ready_i = 1'b0;
      repeat (15) next_cycle();
      checks++; if (state_o !== 2'd1 || err_o !== 1'b0) begin failures++;
         $display("FAIL wb_restart got=st%0d e%b exp=st1 e0", state_o, err_o); end
      idle();
      next_cycle();
      $display("test_wait_boundary done");
   endtask

   task automatic test_timeout();
      apply_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      repeat (15) next_cycle();
      checks++; if (state_o !== 2'd1 || err_o !== 1'b0) begin failures++;
         $display("FAIL to_e15 got=st%0d e%b exp=st1 e0", state_o, err_o); end
      next_cycle();
      checks++; if (state_o !== 2'd2 || err_o !== 1'b1) begin failures++;
         $display("FAIL to_e16 got=st%0d e%b exp=st2 e1", state_o, err_o); end
      drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1);
      #1;
      checks++; if ({pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o, ifid_flush_o, idex_flush_o, exmem_flush_o} !== 7'b0010000) begin failures++;
         $display("FAIL to_ctrl got=%b exp=0010000", {pc_write_o, ifid_write_o, pipe_hold_o, idex_bubble_o, ifid_flush_o, idex_flush_o, exmem_flush_o}); end
      next_cycle();
      checks++; if (state_o !== 2'd2 || stall_cnt_o !== 16'd17 || flush_cnt_o !== 16'd0) begin failures++;
         $display("FAIL to_stay got=st%0d s%0d f%0d exp=st2 s17 f0", state_o, stall_cnt_o, flush_cnt_o); end
      idle();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (state_o !== 2'd0 || err_o !== 1'b0 || stall_cnt_o !== 16'd0 || pc_write_o !== 1'b1) begin failures++;
         $display("FAIL to_async_rst got=st%0d e%b s%0d p%b exp=st0 e0 s0 p1", state_o, err_o, stall_cnt_o, pc_write_o); end
      #1 rst_n = 1'b1;
      $display("test_timeout done");
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      repeat (3) next_cycle();
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL mw_state got=%0d exp=1", state_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (state_o !== 2'd0 || stall_cnt_o !== 16'd0) begin failures++;
         $display("FAIL mw_rst got=st%0d s%0d exp=st0 s0", state_o, stall_cnt_o); end
      idle();
      #1 rst_n = 1'b1;
      $display("test_reset_mid_wait done");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++; if (idex_bubble_o !== 1'b1) begin failures++; $display("FAIL bb_c1 got=%b exp=1", idex_bubble_o); end
      next_cycle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      checks++; if (ifid_flush_o !== 1'b1 || pc_write_o !== 1'b1) begin failures++;
         $display("FAIL bb_c2 got=f%b p%b exp=f1 p1", ifid_flush_o, pc_write_o); end
      next_cycle();
      drive(1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0);
      #1;
      checks++; if (pipe_hold_o !== 1'b1 || idex_bubble_o !== 1'b0 || pc_write_o !== 1'b0) begin failures++;
         $display("FAIL bb_c3 got=h%b b%b p%b exp=h1 b0 p0", pipe_hold_o, idex_bubble_o, pc_write_o); end
      next_cycle();
      idle();
      #1;
      checks++; if (state_o !== 2'd1 || pc_write_o !== 1'b1) begin failures++;
         $display("FAIL bb_c4 got=st%0d p%b exp=st1 p1", state_o, pc_write_o); end
      next_cycle();
      checks++; if (state_o !== 2'd0 || stall_cnt_o !== 16'd2 || flush_cnt_o !== 16'd1) begin failures++;
         $display("FAIL bb_end got=st%0d s%0d f%0d exp=st0 s2 f1", state_o, stall_cnt_o, flush_cnt_o); end
      $display("test_back_to_back done");
   endtask

   task automatic test_saturate();
      apply_reset();
      drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (65534) @(posedge clk_i);
      #1;
      checks++; if (stall_cnt_o !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%0h exp=fffe", stall_cnt_o); end
      repeat (70000 - 65534) @(posedge clk_i);
      #1;
      checks++; if (stall_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt_o); end
      checks++; if (flush_cnt_o !== 16'd0) begin failures++; $display("FAIL sat_flush got=%0h exp=0", flush_cnt_o); end
      idle();
      $display("test_saturate done");
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk_i);
      test_reset();
      #2 rst_n = 1'b1;
      test_load_use();
      test_rt_zero();
      test_branch_load();
      test_freeze_branch();
      test_single_freeze();
      test_wait_boundary();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 16, consecutive data-memory freeze cycles before timeout; legal range 2..255.
REQ-002 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port id_rs_i, id_rt_i  input  5 each  source register numbers of the instruction in ID.
REQ-005 Port ex_memread_i  input  1  instruction in EX is a load.
REQ-006 Port ex_rt_i  input  5  destination register of the instruction in EX.
REQ-007 Port branch_taken_i  input  1  resolved taken branch/jump in MEM stage.
REQ-008 Port mem_req_i  input  1  MEM stage issues a data-memory load or store.
REQ-009 Port dm_ready_i  input  1  data memory completes the access this cycle.
REQ-010 Port pc_write_o, ifid_write_o  output  1 each  PC and IF/ID register update enables.
REQ-011 Port pipe_hold_o  output  1  holds ID/EX, EX/MEM and MEM/WB registers.
REQ-012 Port idex_bubble_o  output  1  zeroes ID/EX control bits (inserts NOP).
REQ-013 Port ifid_flush_o, idex_flush_o, exmem_flush_o  output  1 each  squash the stage register.
REQ-014 Port state_o  output  2  FSM state: RUN=0, MEM_WAIT=1, TIMEOUT=2.
REQ-015 Port err_o  output  1  sticky timeout flag.
REQ-016 Port stall_cnt_o, flush_cnt_o  output  16 each  saturating event counters.

Function
REQ-017 Freeze condition F = mem_req_i AND NOT dm_ready_i; load-use condition L = ex_memread_i AND ex_rt_i!=0 AND (ex_rt_i==id_rs_i OR ex_rt_i==id_rt_i).
REQ-018 Control outputs are combinational from the registered state and current inputs, evaluated in this priority: TIMEOUT, F, branch_taken_i, L, normal.
REQ-019 TIMEOUT state: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, all flush/bubble=0, err_o=1, regardless of inputs.
REQ-020 F (not TIMEOUT): pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, no flush, no bubble; a concurrent branch_taken_i is not acted on and takes effect in the first non-freeze cycle, since the held pipeline keeps it asserted.
REQ-021 Branch (no F): pc_write_o=1, ifid_flush_o=idex_flush_o=exmem_flush_o=1, idex_bubble_o=0; an L in the same cycle is ignored.
REQ-022 L only: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, pipe_hold_o=0; exactly one bubble per load-use hazard, since the bubble clears ex_memread_i next cycle.
REQ-023 Normal: pc_write_o=1, ifid_write_o=1, all other control outputs 0.
REQ-024 FSM: RUN->MEM_WAIT on F; MEM_WAIT->RUN on NOT F; MEM_WAIT->TIMEOUT when F and wait counter == WAIT_MAX-1; TIMEOUT exits only on reset.
REQ-025 Wait counter (8 bit): increments on each F cycle; cleared on any NOT F cycle; TIMEOUT entered at the edge ending the WAIT_MAX-th consecutive F cycle.
REQ-026 stall_cnt_o increments by 1 each cycle pc_write_o=0 (including TIMEOUT); saturates at 16'hFFFF.
REQ-027 flush_cnt_o increments by 1 each cycle the branch flush of REQ-021 is applied; saturates at 16'hFFFF.
REQ-028 An F lasting exactly one cycle with dm_ready_i rising the next cycle costs exactly one stall cycle.

Reset
REQ-029 rst_n low asynchronously forces state RUN, wait counter 0, err_o=0, stall_cnt_o=0, flush_cnt_o=0; control outputs then follow Normal/F/branch/L rules.
REQ-030 Reset asserted mid-MEM_WAIT or in TIMEOUT returns to RUN immediately, without waiting for a clock edge.

Verification
REQ-031 ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for one cycle -> pc_write_o=0, idex_bubble_o=1 one cycle; stall_cnt_o=1.
REQ-032 ex_memread_i=1, ex_rt_i=0, id_rs_i=0 -> no stall, pc_write_o=1, stall_cnt_o stays 0.
REQ-033 branch_taken_i=1 and L together for one cycle -> three flushes=1, idex_bubble_o=0, flush_cnt_o=1.
REQ-034 mem_req_i=1, dm_ready_i=0 for 3 cycles, then ready, with branch_taken_i=1 throughout -> state_o=1 for 3 cycles, pipe_hold_o=1, then flushes asserted in cycle 4; stall_cnt_o=3, flush_cnt_o=1.
REQ-035 WAIT_MAX=16, dm_ready_i=0 with mem_req_i=1 for 16 cycles -> state_o=2, err_o=1 after the 16th edge; stays frozen when dm_ready_i later rises; rst_n low -> state_o=0, err_o=0, counters 0.
REQ-036 Force 70000 stall cycles -> stall_cnt_o holds 16'hFFFF.
